// File: rtl/synth_pkg.sv
// synth_pkg: shared register map, reset defaults and per-voice gate states for synth_voice_ctrl.
//   Voice registers live at addr = {voice, offset}; globals sit above the last voice index.
package synth_pkg;
   localparam logic [3:0] OFF_PLAY = 4'h0;
   localparam logic [3:0] OFF_AR = 4'h4;
   localparam logic [3:0] OFF_GATE = 4'hC;
   localparam logic [7:0] GLB_PCM = 8'hC0;
   localparam logic [7:0] GLB_VOL = 8'hF0;
   localparam logic [7:0] GLB_ALLOFF = 8'hF4;
   localparam logic [7:0] GLB_MSCNT = 8'hF8;
   localparam logic [7:0] GLB_MASK = 8'hFC;
   localparam logic [15:0] DEF_INCREMENT = 16'h0C00;
   localparam logic [7:0] DEF_AR = 8'hF0;
   localparam logic [15:0] DEF_VOLUME = 16'h0080;
   localparam logic [15:0] DUR_FOREVER = 16'hFFFF;
   typedef enum logic [1:0] {ST_IDLE, ST_GATED, ST_RETRIG} vstate_t;
endpackage

// File: rtl/synth_gate_timer.sv
// synth_gate_timer: per-voice gate with a down-counting millisecond duration timer.
//   clk, rst (async, active-low)
//   load          play write with non-zero duration (dur = 'hFFFF holds forever)
//   dur           duration in ticks
//   force_en/val  direct gate write; the voice then holds that gate forever
//   clr           all-off: gate 0, timer cleared
//   tick          millisecond tick, sample_strobe  sample-period pulse
//   gate, remain  gate output and remaining ticks
//   Macro SYNTH_RETRIGGER_EN: a load to a gated voice drops the gate until the next
//   sample_strobe so the envelope restarts its attack.
module synth_gate_timer
   import synth_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] dur,
   input  logic        force_en,
   input  logic        force_val,
   input  logic        clr,
   input  logic        tick,
   input  logic        sample_strobe,
   output logic        gate,
   output logic [15:0] remain
);
   logic forever_q;
   logic expire;
   // Writes take priority over the tick, so a write on the expiry edge keeps its value.
   assign expire = tick & ~forever_q & (remain == 16'd1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         remain <= 16'd0;
         forever_q <= 1'b0;
      end else if (clr) begin
         remain <= 16'd0;
         forever_q <= 1'b0;
      end else if (force_en) begin
         remain <= 16'd0;
         forever_q <= 1'b1;
      end else if (load) begin
         remain <= dur;
         forever_q <= (dur == DUR_FOREVER);
      end else if (tick & ~forever_q & (remain != 16'd0))
         remain <= remain - 16'd1;
`ifdef SYNTH_RETRIGGER_EN
   vstate_t state;
   assign gate = (state == ST_GATED);
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         state <= ST_IDLE;
      else if (clr | (force_en & ~force_val))
         state <= ST_IDLE;
      else if (force_en)
         state <= ST_GATED;
      else if (load)
         state <= (state == ST_IDLE) ? ST_GATED : ST_RETRIG;
      else if (expire)
         state <= ST_IDLE;
      else if ((state == ST_RETRIG) & sample_strobe)
         state <= ST_GATED;
`else
   logic gate_q;
   logic unused_strobe;
   assign unused_strobe = sample_strobe;
   assign gate = gate_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         gate_q <= 1'b0;
      else if (clr)
         gate_q <= 1'b0;
      else if (force_en)
         gate_q <= force_val;
      else if (load)
         gate_q <= 1'b1;
      else if (expire)
         gate_q <= 1'b0;
`endif
endmodule

// File: rtl/synth_voice_ctrl.sv
// synth_voice_ctrl: register front end holding per-voice pitch, A/R and gate state.
//   clk, rst (async, active-low)
//   addr, data_in, wen, ren -> data_out, ready   bus access, one accept per strobe
//   sample_strobe, tick_ms                       prescaled one-cycle pulses
//   voice_gate/increment/attack/release          flattened per-voice controls
//   master_volume, pcm                           global mixer gain and direct sample
//   Macro SYNTH_RETRIGGER_EN enables gate retrigger in synth_gate_timer.
module synth_voice_ctrl
   import synth_pkg::*;
#(
   parameter int NUMVOICES = 8,
   parameter int INCBITS = 16,
   parameter int ARBITS = 8,
   parameter int TICK_DIV = 48000,
   parameter int SAMPLE_DIV = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    addr,
   input  logic [31:0]                   data_in,
   input  logic                          wen,
   input  logic                          ren,
   output logic [31:0]                   data_out,
   output logic                          ready,
   output logic                          sample_strobe,
   output logic                          tick_ms,
   output logic [NUMVOICES-1:0]          voice_gate,
   output logic [NUMVOICES*INCBITS-1:0]  voice_increment,
   output logic [NUMVOICES*ARBITS-1:0]   voice_attack,
   output logic [NUMVOICES*ARBITS-1:0]   voice_release,
   output logic [15:0]                   master_volume,
   output logic [15:0]                   pcm
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   logic done_q, accept, wr, rd, all_off, mask_wr;
   logic [TW-1:0] tick_cnt;
   logic [SAMPLE_DIV-1:0] samp_cnt;
   logic [15:0] ms_cnt;
   logic [3:0] vsel, off;
   logic [INCBITS-1:0] inc_q [NUMVOICES];
   logic [ARBITS-1:0] att_q [NUMVOICES];
   logic [ARBITS-1:0] rel_q [NUMVOICES];
   logic [15:0] remain [NUMVOICES];
   logic [NUMVOICES-1:0] load, force_en, force_val, play_wr, ar_wr;
   logic [31:0] rd_val;
   // The access is performed on the accept edge, so data_out and register state are
   // already valid in the first cycle ready is high.
   assign accept = (wen | ren) & ~done_q;
   assign ready = done_q & (wen | ren);
   assign wr = accept & wen;
   assign rd = accept & ren & ~wen;
   assign vsel = addr[7:4];
   assign off = addr[3:0];
   assign all_off = wr & (addr == GLB_ALLOFF);
   assign mask_wr = wr & (addr == GLB_MASK);
   always_comb begin
      rd_val = 32'd0;
      for (int i = 0; i < NUMVOICES; i++) begin
         play_wr[i] = wr & (vsel == 4'(i)) & (off == OFF_PLAY);
         ar_wr[i] = wr & (vsel == 4'(i)) & (off == OFF_AR);
         load[i] = play_wr[i] & (data_in[31:16] != 16'd0);
         force_en[i] = mask_wr | (wr & (vsel == 4'(i)) & (off == OFF_GATE));
         force_val[i] = mask_wr ? data_in[i] : data_in[0];
         if (vsel == 4'(i))
            rd_val = (off == OFF_PLAY) ? {remain[i], 16'(inc_q[i])} :
                     (off == OFF_AR) ? {16'd0, 8'(rel_q[i]), 8'(att_q[i])} :
                     (off == OFF_GATE) ? {31'd0, voice_gate[i]} : 32'd0;
      end
      rd_val = (addr == GLB_PCM) ? {16'd0, pcm} :
               (addr == GLB_VOL) ? {16'd0, master_volume} :
               (addr == GLB_MSCNT) ? {16'd0, ms_cnt} :
               (addr == GLB_MASK) ? 32'(voice_gate) : rd_val;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         done_q <= 1'b0;
         data_out <= 32'd0;
         pcm <= 16'd0;
         master_volume <= DEF_VOLUME;
         tick_cnt <= '0;
         tick_ms <= 1'b0;
         samp_cnt <= '0;
         sample_strobe <= 1'b0;
         ms_cnt <= 16'd0;
         for (int i = 0; i < NUMVOICES; i++) begin
            inc_q[i] <= INCBITS'(DEF_INCREMENT);
            att_q[i] <= ARBITS'(DEF_AR);
            rel_q[i] <= ARBITS'(DEF_AR);
         end
      end else begin
         done_q <= wen | ren;
         if (rd) data_out <= rd_val;
         if (wr & (addr == GLB_PCM)) pcm <= data_in[15:0];
         if (wr & (addr == GLB_VOL)) master_volume <= data_in[15:0];
         tick_ms <= (tick_cnt == TICK_LAST);
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
         sample_strobe <= &samp_cnt;
         samp_cnt <= samp_cnt + SAMPLE_DIV'(1);
         if (tick_ms) ms_cnt <= ms_cnt + 16'd1;
         for (int i = 0; i < NUMVOICES; i++) begin
            if (play_wr[i]) inc_q[i] <= data_in[INCBITS-1:0];
            if (ar_wr[i]) begin
               att_q[i] <= data_in[ARBITS-1:0];
               rel_q[i] <= data_in[8 +: ARBITS];
            end
         end
      end
   for (genvar v = 0; v < NUMVOICES; v++) begin : g_voice
      assign voice_increment[v*INCBITS +: INCBITS] = inc_q[v];
      assign voice_attack[v*ARBITS +: ARBITS] = att_q[v];
      assign voice_release[v*ARBITS +: ARBITS] = rel_q[v];
      synth_gate_timer u_timer (
         .clk(clk),
         .rst(rst),
         .load(load[v]),
         .dur(data_in[31:16]),
         .force_en(force_en[v]),
         .force_val(force_val[v]),
         .clr(all_off),
         .tick(tick_ms),
         .sample_strobe(sample_strobe),
         .gate(voice_gate[v]),
         .remain(remain[v])
      );
   end
endmodule

// File: tb/tb_synth_voice_ctrl.sv
// tb_synth_voice_ctrl: directed vectors with a read-data scoreboard for synth_voice_ctrl.
module tb_synth_voice_ctrl;
   localparam int NV = 8;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [7:0] addr = 8'd0;
   logic [31:0] data_in = 32'd0;
   logic wen = 1'b0;
   logic ren = 1'b0;
   logic [31:0] data_out;
   logic ready, sample_strobe, tick_ms;
   logic [NV-1:0] voice_gate;
   logic [NV*16-1:0] voice_increment;
   logic [NV*8-1:0] voice_attack, voice_release;
   logic [15:0] master_volume, pcm;
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sbq [$];
   logic mon_seen = 1'b0;
   logic [31:0] last_rd = 32'd0;
   logic exp_g;
   always #5 clk = ~clk;
   synth_voice_ctrl #(.NUMVOICES(NV), .INCBITS(16), .ARBITS(8), .TICK_DIV(20), .SAMPLE_DIV(4)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wen(wen), .ren(ren),
      .data_out(data_out), .ready(ready), .sample_strobe(sample_strobe), .tick_ms(tick_ms),
      .voice_gate(voice_gate), .voice_increment(voice_increment), .voice_attack(voice_attack),
      .voice_release(voice_release), .master_volume(master_volume), .pcm(pcm)
   );
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Monitor: each completed read pops one expected word.
   always @(negedge clk) begin
      if (ready && ren && !wen && !mon_seen) begin
         mon_seen = 1'b1;
         if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_unexpected: addr %02h data %08h with empty scoreboard", addr, data_out);
         end else
            chk($sformatf("rd_%02h", addr), data_out, sbq.pop_front());
      end
      if (!ren) mon_seen = 1'b0;
   end
   task automatic wait_ready();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 50);
      if (!ready) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: ready 0 after %0d cycles, required 1", n);
      end
   endtask
   task automatic finish_access();
      @(posedge clk); #1;
      wen = 1'b0;
      ren = 1'b0;
      @(posedge clk); #1;
   endtask
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      addr = a;
      data_in = d;
      wen = 1'b1;
      wait_ready();
      finish_access();
   endtask
   task automatic rd(input logic [7:0] a, input logic [31:0] exp);
      sbq.push_back(exp);
      last_rd = exp;
      addr = a;
      ren = 1'b1;
      wait_ready();
      finish_access();
   endtask
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick_ms && n < 100);
      if (!tick_ms) begin
         n_vec++;
         n_err++;
         $display("FAIL tick_timeout: tick_ms 0 after %0d cycles, required 1", n);
      end
      @(posedge clk); #1;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gate", voice_gate, 0);
      chk("rst_inc", voice_increment, {NV{16'h0C00}});
      chk("rst_att", voice_attack, {NV{8'hF0}});
      chk("rst_rel", voice_release, {NV{8'hF0}});
      chk("rst_vol", master_volume, 16'h0080);
      chk("rst_pcm", pcm, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_ready", ready, 0);
      chk("rst_strobes", {sample_strobe, tick_ms}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rd(8'h04, 32'h0000F0F0);
      rd(8'hF0, 32'h00000080);
      rd(8'h10, 32'h00000C00);
      // play voice 1 for three ticks
      wait_tick();
      wr(8'h10, 32'h0003_1234);
      chk("inc1", voice_increment[31:16], 16'h1234);
      chk("gate1_on", voice_gate[1], 1);
      rd(8'h10, 32'h0003_1234);
      wait_tick();
      rd(8'h10, 32'h0002_1234);
      wait_tick();
      rd(8'h10, 32'h0001_1234);
      rd(8'h1C, 32'h0000_0001);
      wait_tick();
      chk("gate1_off", voice_gate[1], 0);
      rd(8'h10, 32'h0000_1234);
      rd(8'h1C, 32'h0000_0000);
      // held write strobe: ready from cycle 2, single accept
      addr = 8'hF0;
      data_in = 32'h0000_1111;
      wen = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("hold_ready_c%0d", c), ready, (c >= 2));
         @(posedge clk); #1;
      end
      wen = 1'b0;
      #1 chk("hold_ready_drop", ready, 0);
      @(posedge clk); #1;
      rd(8'hF0, 32'h0000_1111);
      // write and read together: write wins, data_out untouched
      addr = 8'hF0;
      data_in = 32'h0000_5555;
      wen = 1'b1;
      ren = 1'b1;
      wait_ready();
      finish_access();
      chk("both_dout", data_out, last_rd);
      chk("both_vol", master_volume, 16'h5555);
      // reserved, unmapped, A/R and pcm
      wr(8'h08, 32'hDEAD_BEEF);
      rd(8'h08, 32'h0);
      wr(8'h94, 32'h0000_1234);
      chk("unmapped_att", voice_attack, {NV{8'hF0}});
      rd(8'h90, 32'h0);
      wr(8'h54, 32'h0000_3C5A);
      rd(8'h54, 32'h0000_3C5A);
      chk("att5", voice_attack[47:40], 8'h5A);
      chk("rel5", voice_release[47:40], 8'h3C);
      wr(8'hC0, 32'hABCD_8001);
      rd(8'hC0, 32'h0000_8001);
      chk("pcm", pcm, 16'h8001);
      // gate mask holds forever, all-off clears
      wr(8'hFC, 32'h0000_00A5);
      chk("mask_gate", voice_gate, 8'hA5);
      rd(8'hFC, 32'h0000_00A5);
      rd(8'h0C, 32'h0000_0001);
      repeat (100) wait_tick();
      chk("mask_hold", voice_gate, 8'hA5);
      wr(8'hF4, 32'h0);
      chk("alloff_gate", voice_gate, 0);
      rd(8'hFC, 32'h0);
      // play write on the expiry edge of voice 2
      wait_tick();
      wr(8'h20, 32'h0001_00AA);
      chk("gate2_on", voice_gate[2], 1);
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!tick_ms && n < 100);
      end
      addr = 8'h20;
      data_in = 32'h0001_0100;
      wen = 1'b1;
      wait_ready();
      finish_access();
      chk("collide_gate2", voice_gate[2], 1);
      rd(8'h20, 32'h0001_0100);
      wait_tick();
      chk("gate2_expire", voice_gate[2], 0);
      // play write to an already gated voice
      wr(8'h00, 32'hFFFF_0777);
      chk("gate0_forever", voice_gate[0], 1);
      addr = 8'h00;
      data_in = 32'h0005_0888;
      wen = 1'b1;
      @(posedge clk); #1;
      wen = 1'b0;
`ifdef SYNTH_RETRIGGER_EN
      exp_g = 1'b0;
`else
      exp_g = 1'b1;
`endif
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk($sformatf("retrig_gate0_%0d", i), voice_gate[0], exp_g);
         if (sample_strobe) exp_g = 1'b1;
      end
      chk("inc0", voice_increment[15:0], 16'h0888);
      if (sbq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_leftover: %0d reads pending, required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/synth_voice_ctrl.md
Name: synth_voice_ctrl

Overview:
- Parametrised successor to the audio synth's CPU register front end; holds per-voice control state for NUMVOICES voices.
- Sits between the memory bus and the voice/mixer/dac chain. Drives flattened pitch, A/R and gate buses plus master volume and pcm.
- New behaviour: register readback, one-accept-per-strobe handshake, down-counting gate timers (no wrap compare), a millisecond tick prescaler and a sample strobe.
- Voice generators, mixers and dac stay outside this block.

Parameters:
NUMVOICES, 8, voice count (1..12); voice index is addr[7:4].
INCBITS, 16, pitch increment width (<=16).
ARBITS, 8, attack/release width (<=8).
TICK_DIV, 48000, clk cycles per tick_ms (1 ms at 48 MHz).
SAMPLE_DIV, 10, sample_strobe period is 2**SAMPLE_DIV clk cycles.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  asynchronous, active-low reset.
addr  in  8  register byte address.
data_in  in  32  write data.
wen  in  1  write strobe; held until ready.
ren  in  1  read strobe; held until ready.
data_out  out  32  registered read data.
ready  out  1  access complete.
sample_strobe  out  1  one-cycle pulse per sample period.
tick_ms  out  1  one-cycle pulse every TICK_DIV cycles.
voice_gate  out  NUMVOICES  gate, bit i = voice i.
voice_increment  out  NUMVOICES*INCBITS  pitch increments, voice i at [i*INCBITS +: INCBITS].
voice_attack  out  NUMVOICES*ARBITS  attack rates.
voice_release  out  NUMVOICES*ARBITS  release rates.
master_volume  out  16  mixer gain.
pcm  out  16  direct PCM sample.

Behaviour:
- Reset (rst low, asynchronous) sets:
  - outputs: gates 0, every increment 'hC00, attack/release 'hF0, master_volume 'h0080, pcm 0, data_out 0, ready 0, both strobes 0.
  - internal state: timers 0, prescalers 0.
- Reset mid-access abandons the access; the master re-issues it.
- Handshake:
  - Accept when (wen|ren) is high and the done flag is clear. Accept captures addr/data and sets done.
  - done clears the cycle after wen|ren is low.
  - ready = done_q & (wen|ren), so ready drops combinationally with the strobe.
  - Write accepted at edge N: register updated at edge N+1; ready high from N+1.
  - Read accepted at edge N: data_out valid and ready high from N+1.
  - A held strobe never causes a second accept. wen and ren together: write wins, data_out unchanged.
- Voice registers (v = addr[7:4] < NUMVOICES):
  - off 0 write: increment <= data[INCBITS-1:0]; dur = data[31:16].
    - dur 0: pitch only.
    - dur 'hFFFF: gate=1, hold forever.
    - otherwise: gate=1, remain=dur.
  - off 0 read: {remain, zero-extended increment}.
  - off 4 write: attack <= data[7:0], release <= data[15:8], truncated to ARBITS. Read returns the same layout.
  - off 8: reserved. Writes ignored, reads 0.
  - off C write: gate <= data[0], forever. Read returns {31'b0, gate}.
- Global registers:
  - 0xC0: pcm.
  - 0xF0: master_volume (read/write).
  - 0xF4 write: all gates 0, all timers cleared.
  - 0xF8 read: 16-bit free-running ms counter.
  - 0xFC write: gate[i] <= data[i], forever. Read returns the gate mask.
- Unmapped writes are ignored; unmapped reads return 0. Voice index >= NUMVOICES is unmapped.
- Timers:
  - On tick_ms, each non-forever voice with remain>0 decrements.
  - The decrement 1->0 clears gate on the same edge.
  - A register write to a voice on its expiry edge wins (write value kept).
  - remain never wraps.
- Prescalers:
  - tick_ms fires when the counter reaches TICK_DIV-1, then the counter returns to 0.
  - sample_strobe fires when the SAMPLE_DIV-bit counter reaches all-ones.

Optional Feature:
- Macro: SYNTH_RETRIGGER_EN.
- Defined: an off-0 write with dur!=0 to an already-gated voice forces that voice's gate 0 until the next sample_strobe, then 1. This gives the envelope a fresh attack. Per-voice states are IDLE, GATED, RETRIG. Timer reload happens at the write; RETRIG time counts toward the duration. All-off or a gate=0 write in RETRIG goes to IDLE.
- Undefined: the gate stays 1 and only the timer reloads.

Decomposition:
- Shared package synth_pkg:
  - register offsets: OFF_PLAY, OFF_AR, OFF_GATE, GLB_PCM, GLB_VOL, GLB_ALLOFF, GLB_MSCNT, GLB_MASK.
  - reset defaults: DEF_INCREMENT 'hC00, DEF_AR 'hF0, DEF_VOLUME 'h0080.
  - forever code DUR_FOREVER 'hFFFF.
- Sub-module synth_gate_timer, one instance per voice:
  - inputs: load, dur, force_gate, tick, sample_strobe.
  - holds remain, forever flag, gate and (optionally) the retrigger state.

Test Plan:
1. After reset, read 0x04 -> 'h0000F0F0. Read 0xF0 -> 'h00000080. voice_gate == 0.
2. Write 0x10 = 'h0003_1234 -> increment[1]='h1234, gate[1]=1 from edge N+1. Gate clears on the 3rd tick_ms. Read 0x10 in between shows remain counting 3,2,1.
3. Hold wen 10 cycles -> exactly one accept, ready high cycles 2..10, low the cycle wen drops.
4. Write 0xFC = 'hA5 -> gates 'hA5, no expiry after 100 ticks. Write 0xF4 -> gates 0.
5. Write 0x20 = 'h0001_0100 colliding with the expiry edge of a pending voice-2 timer -> gate[2] stays 1, remain=1.
6. SYNTH_RETRIGGER_EN: play write to gated voice 0 -> gate[0]=0 until the next sample_strobe, then 1. Without the macro, gate[0] stays 1 throughout.
